// File: rtl/useq_ctl.sv
// Microprogram sequencer: holds upc/ctrl, drives a 1-clock-latency microcode ROM,
// and computes the next microaddress (NEXT/COND/MAP/CALL/RET) with an internal return stack.
module useq_ctl #(
    parameter int AW    = 5,
    parameter int CW    = 19,
    parameter int NCOND = 4,
    parameter int MAPW  = 3,
    parameter int SD    = 4,
    localparam int CSW  = (NCOND > 1) ? $clog2(NCOND) : 1,
    localparam int MW   = CW + 3 + CSW + AW,
    localparam int SPW  = $clog2(SD + 1)
) (
    input  logic             clk,
    input  logic             nclr,
    input  logic             step,
    input  logic [MW-1:0]    rom_q,
    input  logic [NCOND-1:0] cond,
    input  logic [MAPW-1:0]  map_in,
    output logic [AW-1:0]    upc,
    output logic [CW-1:0]    ctrl,
    output logic             ready,
    output logic [SPW-1:0]   sp,
    output logic             err
);

    localparam int IW = (SD > 1) ? $clog2(SD) : 1;
    localparam int CP = 2 ** CSW;

    localparam logic [2:0] OP_COND = 3'd1;
    localparam logic [2:0] OP_MAP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    typedef enum logic {S_WAIT, S_RDY} state_t;

    typedef struct packed {
        logic [CW-1:0]  ctrl;
        logic [2:0]     op;
        logic [CSW-1:0] csel;
        logic [AW-1:0]  nxt;
    } uword_t;

    uword_t         uw;
    state_t         state, state_nx;
    logic           pending, pending_nx, exec;
    logic [AW-1:0]  upc_nx;
    logic [CW-1:0]  ctrl_nx;
    logic [SPW-1:0] sp_nx;
    logic           err_nx, push;
    logic [CP-1:0]  cond_ext;
    logic           cond_hit, stk_full, stk_empty;
    logic [IW-1:0]  wr_idx, rd_idx;
    logic [AW-1:0]  stk [2**IW];

    assign uw = uword_t'(rom_q);

    // Zero-padding to a power of two makes out-of-range csel read as false.
    assign cond_ext  = CP'(cond);
    assign cond_hit  = cond_ext[uw.csel];
    assign stk_full  = (sp == SPW'(SD));
    assign stk_empty = (sp == '0);
    assign wr_idx    = sp[IW-1:0];
    assign rd_idx    = IW'(sp - SPW'(1));

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            state   <= S_WAIT;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
        end
    end

    // WAIT covers the ROM fetch; a step arriving then is parked in pending.
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        exec       = 1'b0;
        ready      = 1'b0;
        case (state)
            S_WAIT: begin
                state_nx = S_RDY;
                if (step) pending_nx = 1'b1;
            end
            S_RDY: begin
                ready = 1'b1;
                if (step || pending) begin
                    exec       = 1'b1;
                    pending_nx = 1'b0;
                    state_nx   = S_WAIT;
                end
            end
        endcase
    end

    always_comb begin
        upc_nx  = upc;
        ctrl_nx = ctrl;
        sp_nx   = sp;
        err_nx  = err;
        push    = 1'b0;
        if (exec) begin
            ctrl_nx = uw.ctrl;
            upc_nx  = uw.nxt;
            case (uw.op)
                OP_COND: if (cond_hit) upc_nx = uw.nxt | AW'(1);
                OP_MAP:  upc_nx = uw.nxt | AW'(map_in);
                OP_CALL: begin
                    if (stk_full) begin
                        err_nx = 1'b1;
                    end else begin
                        push  = 1'b1;
                        sp_nx = sp + SPW'(1);
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        upc_nx = '0;
                        err_nx = 1'b1;
                    end else begin
                        upc_nx = stk[rd_idx];
                        sp_nx  = sp - SPW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            upc  <= '0;
            ctrl <= '0;
            sp   <= '0;
            err  <= 1'b0;
        end else begin
            upc  <= upc_nx;
            ctrl <= ctrl_nx;
            sp   <= sp_nx;
            err  <= err_nx;
        end
    end

    // Return addresses are pure data; occupancy lives in sp, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) stk[wr_idx] <= upc + AW'(1);
    end

endmodule

// File: tb/tb_useq_ctl.sv
// Bench for useq_ctl: directed vector table, hand-written multi-cycle sequences,
// and random microprograms checked each cycle against a queue-based reference model.
module tb_useq_ctl;

    localparam int AW = 5, CW = 19, NCOND = 3, MAPW = 3, SD = 2;
    localparam int CSW = 2, MW = CW + 3 + CSW + AW, SPW = 2;

    logic             clk, nclr, step;
    logic [MW-1:0]    rom_q;
    logic [NCOND-1:0] cond;
    logic [MAPW-1:0]  map_in;
    logic [AW-1:0]    upc;
    logic [CW-1:0]    ctrl;
    logic             ready, err;
    logic [SPW-1:0]   sp;

    logic [MW-1:0] rom [32];
    int n_tests = 0, n_fail = 0;

    // reference model state
    int            m_upc, m_err, m_req, m_age;
    logic [CW-1:0] m_ctrl;
    int            m_stk[$];

    useq_ctl #(.AW(AW), .CW(CW), .NCOND(NCOND), .MAPW(MAPW), .SD(SD)) dut (
        .clk(clk), .nclr(nclr), .step(step), .rom_q(rom_q), .cond(cond),
        .map_in(map_in), .upc(upc), .ctrl(ctrl), .ready(ready), .sp(sp), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[upc];

    typedef struct {
        logic [CW-1:0] c;
        logic [2:0]    op;
        logic [1:0]    cs;
        logic [4:0]    nx;
        logic [2:0]    cnd;
        logic [2:0]    mp;
        int            eupc, esp, eerr;
    } vec_t;

    vec_t vt [12];

    function automatic logic [MW-1:0] mk(input logic [CW-1:0] c, input logic [2:0] op,
                                         input logic [1:0] cs, input logic [4:0] nx);
        return {c, op, cs, nx};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rom_clr();
        for (int a = 0; a < 32; a++) rom[a] = mk('0, 3'd0, 2'd0, 5'd0);
    endtask

    // Called at a negedge; asserts reset mid-cycle to exercise the async path.
    task automatic do_reset();
        nclr = 1'b0;
        step = 1'b0;
        #1;
        chk("rst_upc",   32'(upc),   32'd0);
        chk("rst_ctrl",  32'(ctrl),  32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_sp",    32'(sp),    32'd0);
        chk("rst_err",   32'(err),   32'd0);
        m_upc = 0; m_ctrl = '0; m_stk.delete(); m_err = 0; m_req = 0; m_age = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nclr = 1'b1;
    endtask

    task automatic model_exec(input logic [MW-1:0] w);
        logic [2:0] op;
        logic [1:0] cs;
        int         nx;
        op = w[9:7];
        cs = w[6:5];
        nx = int'(w[4:0]);
        m_ctrl = w[MW-1 -: CW];
        case (op)
            3'd1: m_upc = (int'(cs) < NCOND && ((cond >> cs) & 3'd1) != 3'd0) ? (nx | 1) : nx;
            3'd2: m_upc = nx | int'(map_in);
            3'd3: begin
                if (m_stk.size() == SD) m_err = 1;
                else m_stk.push_back((m_upc + 1) % 32);
                m_upc = nx;
            end
            3'd4: begin
                if (m_stk.size() == 0) begin m_upc = 0; m_err = 1; end
                else m_upc = m_stk.pop_back();
            end
            default: m_upc = nx;
        endcase
    endtask

    // One clock: compare outputs with the model, drive step, advance model, move to next negedge.
    task automatic cyc(input logic s);
        logic rdy;
        rdy = (m_age >= 1);
        chk("upc",   32'(upc),   32'(m_upc));
        chk("ctrl",  32'(ctrl),  32'(m_ctrl));
        chk("ready", 32'(ready), 32'(rdy));
        chk("sp",    32'(sp),    32'(m_stk.size()));
        chk("err",   32'(err),   32'(m_err));
        step = s;
        if (!rdy) begin
            if (s) m_req = 1;
            m_age++;
        end else if (s || m_req != 0) begin
            model_exec(rom[m_upc]);
            m_req = 0;
            m_age = 0;
        end else begin
            m_age++;
        end
        @(posedge clk);
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic adv();
        cyc(1'b0);
        cyc(1'b1);
    endtask

    initial begin
        nclr = 1'b0; step = 1'b0; cond = '0; map_in = '0;
        rom_clr();
        vt[0]  = '{19'h155AA, 3'd0, 2'd0, 5'h07, 3'b000, 3'b000, 32'h07, 0, 0};
        vt[1]  = '{19'h00001, 3'd1, 2'd2, 5'h10, 3'b100, 3'b000, 32'h11, 0, 0};
        vt[2]  = '{19'h00002, 3'd1, 2'd2, 5'h10, 3'b000, 3'b000, 32'h10, 0, 0};
        vt[3]  = '{19'h00003, 3'd1, 2'd3, 5'h10, 3'b111, 3'b000, 32'h10, 0, 0};
        vt[4]  = '{19'h7FFFF, 3'd1, 2'd0, 5'h0A, 3'b001, 3'b000, 32'h0B, 0, 0};
        vt[5]  = '{19'h12345, 3'd2, 2'd0, 5'h08, 3'b000, 3'b101, 32'h0D, 0, 0};
        vt[6]  = '{19'h00F0F, 3'd2, 2'd1, 5'h1F, 3'b111, 3'b010, 32'h1F, 0, 0};
        vt[7]  = '{19'h2AAAA, 3'd3, 2'd0, 5'h14, 3'b000, 3'b000, 32'h14, 1, 0};
        vt[8]  = '{19'h00055, 3'd4, 2'd0, 5'h09, 3'b000, 3'b000, 32'h00, 0, 1};
        vt[9]  = '{19'h01234, 3'd5, 2'd0, 5'h03, 3'b111, 3'b111, 32'h03, 0, 0};
        vt[10] = '{19'h04321, 3'd7, 2'd3, 5'h1C, 3'b000, 3'b000, 32'h1C, 0, 0};
        vt[11] = '{19'h00100, 3'd1, 2'd1, 5'h11, 3'b010, 3'b000, 32'h11, 0, 0};
        @(negedge clk);

        foreach (vt[i]) begin
            rom_clr();
            rom[0] = mk(vt[i].c, vt[i].op, vt[i].cs, vt[i].nx);
            do_reset();
            cyc(1'b0);
            chk($sformatf("vec%0d_ready_first", i), 32'(ready), 32'd1);
            cond = vt[i].cnd; map_in = vt[i].mp;
            cyc(1'b1);
            chk($sformatf("vec%0d_upc", i),   32'(upc),   32'(vt[i].eupc));
            chk($sformatf("vec%0d_ctrl", i),  32'(ctrl),  32'(vt[i].c));
            chk($sformatf("vec%0d_sp", i),    32'(sp),    32'(vt[i].esp));
            chk($sformatf("vec%0d_err", i),   32'(err),   32'(vt[i].eerr));
            chk($sformatf("vec%0d_ready_after", i), 32'(ready), 32'd0);
        end
        cond = '0; map_in = '0;

        // call/return round trip
        rom_clr();
        rom[0] = mk(19'h00010, 3'd0, 2'd0, 5'h03);
        rom[3] = mk(19'h11111, 3'd3, 2'd0, 5'h14);
        rom[5'h14] = mk(19'h22222, 3'd4, 2'd0, 5'h00);
        rom[4] = mk(19'h33333, 3'd0, 2'd0, 5'h04);
        do_reset();
        adv(); chk("cr_upc0", 32'(upc), 32'h03);
        adv(); chk("cr_upc1", 32'(upc), 32'h14); chk("cr_sp1", 32'(sp), 32'd1);
        adv(); chk("cr_upc2", 32'(upc), 32'h04); chk("cr_sp2", 32'(sp), 32'd0);
        chk("cr_err", 32'(err), 32'd0);

        // return address wraps from 0x1F to 0
        rom_clr();
        rom[0] = mk(19'h00001, 3'd0, 2'd0, 5'h1F);
        rom[5'h1F] = mk(19'h00002, 3'd3, 2'd0, 5'h06);
        rom[6] = mk(19'h00003, 3'd4, 2'd0, 5'h0E);
        do_reset();
        adv(); adv(); chk("wrap_upc_call", 32'(upc), 32'h06); chk("wrap_sp", 32'(sp), 32'd1);
        adv(); chk("wrap_upc_ret", 32'(upc), 32'h00); chk("wrap_err", 32'(err), 32'd0);

        // overflow: third nested call jumps but does not push
        rom_clr();
        rom[0] = mk(19'h00001, 3'd3, 2'd0, 5'h01);
        rom[1] = mk(19'h00002, 3'd3, 2'd0, 5'h02);
        rom[2] = mk(19'h00003, 3'd3, 2'd0, 5'h05);
        rom[5] = mk(19'h00004, 3'd0, 2'd0, 5'h05);
        do_reset();
        adv(); adv(); chk("ovf_err_before", 32'(err), 32'd0);
        adv();
        chk("ovf_upc", 32'(upc), 32'h05); chk("ovf_sp", 32'(sp), 32'd2); chk("ovf_err", 32'(err), 32'd1);
        adv(); adv(); chk("ovf_err_sticky", 32'(err), 32'd1);
        do_reset(); cyc(1'b0);

        // step during WAIT, held into RDY: exactly one advance
        rom_clr();
        rom[0] = mk(19'h00AAA, 3'd0, 2'd0, 5'h02);
        rom[2] = mk(19'h00BBB, 3'd0, 2'd0, 5'h09);
        do_reset();
        cyc(1'b1);
        chk("hs_pending_ready", 32'(ready), 32'd1);
        cyc(1'b1);
        chk("hs_upc_exec", 32'(upc), 32'h02);
        cyc(1'b0); cyc(1'b0); cyc(1'b0);
        chk("hs_upc_single", 32'(upc), 32'h02);

        // reset while a step is pending aborts it
        do_reset();
        adv(); chk("ab_upc_pre", 32'(upc), 32'h02);
        cyc(1'b1);
        do_reset();
        repeat (4) cyc(1'b0);
        chk("ab_upc_hold", 32'(upc), 32'h00);
        chk("ab_ctrl_hold", 32'(ctrl), 32'h0);

        // random microprograms against the model
        for (int seg = 0; seg < 5; seg++) begin
            for (int a = 0; a < 32; a++)
                rom[a] = mk(CW'($urandom), 3'($urandom_range(0, 7)),
                            2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            do_reset();
            for (int c = 0; c < 200; c++) begin
                cond   = 3'($urandom);
                map_in = 3'($urandom);
                if ($urandom_range(0, 59) == 0) do_reset();
                else cyc($urandom_range(0, 1) == 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/useq_ctl.md
# useq_ctl

Parametrised microprogram sequencer for the CISC control path, successor to the fixed 5-bit microaddress unit. It holds the microprogram counter and the microinstruction control register, and drives the address of an external synchronous microcode ROM (one-clock read latency). Each step computes the next microaddress from the fetched microword. Supported sequencing modes are sequential jump, two-way conditional branch, opcode map dispatch, and micro-subroutine call/return on an internal return stack. A ready/pending handshake absorbs the ROM latency.

## Interface
- AW, 5, microaddress width
- CW, 19, control field width; ctrl is driven out as the ALU/bus/load strobes
- NCOND, 4, number of condition inputs; CSW = max(1, clog2(NCOND)) derived
- MAPW, 3, width of the opcode map field (AW >= MAPW)
- SD, 4, return stack depth (>= 1)
- Derived: MW = CW + 3 + CSW + AW, the microword width
- clk  in  1  system clock; all state changes on the rising edge
- nclr  in  1  asynchronous active-low reset
- step  in  1  one-cycle advance request (t2-derived pulse)
- rom_q  in  MW  microword at address upc, valid one clk after upc changes
- cond  in  NCOND  branch test conditions
- map_in  in  MAPW  opcode field from IR
- upc  out  AW  microaddress to ROM
- ctrl  out  CW  registered control field
- ready  out  1  rom_q is valid and a step will execute this cycle
- sp  out  clog2(SD+1)  return stack occupancy
- err  out  1  sticky stack fault

## Operation
- Microword fields: rom_q[MW-1 -: CW] = ctrl; then op[2:0]; then csel[CSW-1:0]; rom_q[AW-1:0] = nxt.
- Next-address rules, evaluated at an executed step:
  - op 000 NEXT: upc <= nxt.
  - op 001 COND: upc <= nxt | 1 if cond[csel] = 1, else nxt. csel >= NCOND reads as false.
  - op 010 MAP: upc <= nxt | zero-extended map_in (OR into the low MAPW bits).
  - op 011 CALL: push (upc + 1) mod 2^AW, then upc <= nxt. If the stack is full, the jump is still taken, the push is dropped and err <= 1.
  - op 100 RET: upc <= top of stack, then pop. If the stack is empty, upc <= 0 and err <= 1.
  - op 101–111: reserved, behave as NEXT.
- At every executed step, ctrl <= the ctrl field of rom_q, whatever the op.
- FSM states:
  - WAIT: ROM is fetching upc; ready = 0. Always goes to RDY on the next clock.
  - RDY: ready = 1. On step or pending, execute, clear pending and go to WAIT. Otherwise stay in RDY.
- pending (one-deep):
  - Set by step in WAIT.
  - Further steps while pending = 1 are discarded.
  - Cleared when its step executes.
- Stack is LIFO; sp = 0 means empty and sp = SD means full. CALL and RET never occur in the same step.
- err is cleared only by nclr.

## Timing
- Reset (nclr = 0, asynchronous) sets: upc = 0, ctrl = 0, sp = 0, err = 0, pending = 0, state = WAIT, ready = 0.
- First RDY occurs in the second clock after nclr deasserts.
- Reset asserted mid-operation aborts everything, including a pending step. No stale ctrl survives.
- Step executed in cycle k:
  - upc and ctrl update at the end of k.
  - Cycle k+1 is WAIT.
  - Cycle k+2 is RDY with the new rom_q.
  - Minimum step period is 2 clocks; a step in k+1 executes in k+2.
- cond and map_in are sampled only in the executing cycle and must be stable in that cycle.
- ctrl is held constant between executed steps.

## Test plan
- Reset/sequential:
  - Stimulus: hold nclr = 0, release, ROM[0] = NEXT nxt = 7 with ctrl = 0x155AA, step in first RDY.
  - Required: upc = 0 and ctrl = 0 during reset; ready in cycle 2; after the step upc = 7 and ctrl = 0x155AA; ready = 0 for one cycle.
- COND:
  - Stimulus: ROM[4] = COND csel = 2 nxt = 0x10; run with cond = 4'b0100, then again with cond = 0.
  - Required: upc = 0x11, then upc = 0x10. With csel = 3 and NCOND = 3, upc = 0x10.
- MAP:
  - Stimulus: ROM[2] = MAP nxt = 0x08, map_in = 3'b101.
  - Required: upc = 0x0D.
- CALL/RET:
  - Stimulus: CALL at upc 3 with nxt = 0x14; RET at 0x14.
  - Required: sp goes 0 -> 1 -> 0 and upc = 0x14 then 4. A CALL at upc 0x1F pushes 0 (wrap).
- Stack faults (SD = 2):
  - Stimulus: three nested CALLs; separately, a RET with sp = 0.
  - Required: the third jump is taken, sp stays 2 and err = 1. The empty RET gives upc = 0 and err = 1. err stays 1 until nclr.
- Handshake and reset abort:
  - Stimulus: step in WAIT, plus a second step in that same cycle.
  - Required: exactly one advance, executed in the next cycle.
  - Stimulus: nclr pulsed while pending = 1.
  - Required: upc = 0 and no advance after release until a new step.
